// File: rtl/program_loader.sv
// Boot loader: length-prefixed big-endian image from UART into instruction RAM, then one ack byte.
// Writes land one cycle after a word's 4th byte; every rx strobe is accepted, and the ack waits for tx_busy to clear.
module program_loader #(
  parameter int          ADDR_W  = 15,
  parameter int unsigned DEPTH   = 2**ADDR_W,
  parameter logic [7:0]  ACK_OK  = 8'hAA,
  parameter logic [7:0]  ACK_ERR = 8'hEE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rdata,
  input  logic              rx_ready,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN    = 3'd0,
    S_DATA   = 3'd1,
    S_ACK    = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4,
    S_ACKERR = 3'd5
  } state_t;

  localparam logic [31:0]     DEPTH32 = 32'(DEPTH);
  localparam logic [ADDR_W:0] WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          bc_q, bc_d;
  logic [31:0]         sh_q, sh_d;
  logic [31:0]         len_q, len_d;
  logic [ADDR_W:0]     wc_q, wc_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [31:0] word;
  logic        accept;
  logic        word_done;

  assign word      = {sh_q[23:0], rdata};
  assign accept    = rx_ready && ((state_q == S_LEN) || (state_q == S_DATA));
  assign word_done = accept && (bc_q == 2'd3);

  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    sh_d         = sh_q;
    len_d        = len_q;
    wc_d         = wc_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    // Status flags follow the registered state, so they trail the ack strobe by one cycle.
    done_d       = (state_q == S_DONE);
    error_d      = (state_q == S_ERR);

    if (accept) begin
      sh_d = word;
      bc_d = bc_q + 2'd1;
    end

    case (state_q)
      S_LEN: begin
        if (word_done) begin
          len_d = word;
          if (word > DEPTH32) begin
            state_d = S_ACKERR;
          end else if (word == 32'd0) begin
            state_d = S_ACK;
          end else begin
            wc_d    = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          imem_we_d    = 1'b1;
          imem_wdata_d = word;
          imem_addr_d  = wc_q[ADDR_W-1:0];
          wc_d         = wc_q + WC_ONE;
          if (32'(wc_q) == (len_q - 32'd1)) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (!tx_busy) begin
          tx_data_d  = ACK_OK;
          tx_start_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_ACKERR: begin
        if (!tx_busy) begin
          tx_data_d  = ACK_ERR;
          tx_start_d = 1'b1;
          state_d    = S_ERR;
        end
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_LEN;
      bc_q         <= '0;
      sh_q         <= '0;
      len_q        <= '0;
      wc_q         <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      sh_q         <= sh_d;
      len_q        <= len_d;
      wc_q         <= wc_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 16-word instruction memory.
module tb_program_loader;

  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic [7:0]    rdata;
  logic          rx_ready;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          error;

  int checks;
  int failures;
  int cyc;

  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  int            wr_cyc  [64];
  int            wr_cnt;
  int            tx_cnt;
  int            tx_cyc;
  logic [7:0]    tx_last;
  int            done_cyc;

  program_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rdata     (rdata),
    .rx_ready  (rx_ready),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; tasks compare against it.
  always @(negedge clk) begin
    if (rstn) begin
      if (imem_we) begin
        if (wr_cnt < 64) begin
          wr_addr[wr_cnt] = imem_addr;
          wr_data[wr_cnt] = imem_wdata;
          wr_cyc[wr_cnt]  = cyc;
        end
        wr_cnt = wr_cnt + 1;
      end
      if (tx_start) begin
        tx_cnt  = tx_cnt + 1;
        tx_cyc  = cyc;
        tx_last = tx_data;
      end
      if (done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int c);
    c        = cyc;
    rdata    = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output int c);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31-8*i -: 8], c);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    rx_ready = 1'b0;
    tx_busy  = 1'b0;
    rdata    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    wr_cnt   = 0;
    tx_cnt   = 0;
    tx_cyc   = -1;
    tx_last  = 8'h00;
    done_cyc = -1;
    rstn     = 1'b1;
  endtask

  task automatic test_reset();
    logic [AW+43:0] outs;
    do_reset();
    rstn = 1'b0;
    #2;
    outs = {tx_data, tx_start, imem_we, imem_addr, imem_wdata, done, error};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs_asserted got=%h exp=0", outs);
    end
    do_reset();
    idle(3);
    outs = {tx_data, tx_start, imem_we, imem_addr, imem_wdata, done, error};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL reset_outputs_idle got=%h exp=0", outs);
    end
  endtask

  task automatic test_two_words();
    int c;
    do_reset();
    send_word(32'h0000_0002, c);
    send_word(32'h1234_5678, c);
    send_word(32'h9ABC_DEF0, c);
    idle(6);
    checks++;
    if (wr_cnt !== 2) begin failures++; $display("FAIL two_wr_cnt got=%0d exp=2", wr_cnt); end
    checks++;
    if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h1234_5678) begin
      failures++; $display("FAIL two_w0 got=%h@%0d exp=12345678@0", wr_data[0], wr_addr[0]);
    end
    checks++;
    if (wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h9ABC_DEF0) begin
      failures++; $display("FAIL two_w1 got=%h@%0d exp=9abcdef0@1", wr_data[1], wr_addr[1]);
    end
    checks++;
    if (wr_cyc[1] !== c + 1) begin failures++; $display("FAIL two_wr_lat got=%0d exp=%0d", wr_cyc[1], c + 1); end
    checks++;
    if (tx_cnt !== 1 || tx_last !== 8'hAA) begin
      failures++; $display("FAIL two_ack got=%0d/%h exp=1/aa", tx_cnt, tx_last);
    end
    checks++;
    if (tx_cyc !== c + 2) begin failures++; $display("FAIL two_tx_lat got=%0d exp=%0d", tx_cyc, c + 2); end
    checks++;
    if (done_cyc !== c + 3) begin failures++; $display("FAIL two_done_lat got=%0d exp=%0d", done_cyc, c + 3); end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++; $display("FAIL two_flags got=%b%b exp=10", done, error);
    end
  endtask

  task automatic test_len_zero();
    int c;
    do_reset();
    send_word(32'h0000_0000, c);
    idle(6);
    checks++;
    if (wr_cnt !== 0) begin failures++; $display("FAIL zero_wr_cnt got=%0d exp=0", wr_cnt); end
    checks++;
    if (tx_cnt !== 1 || tx_last !== 8'hAA || tx_cyc !== c + 2) begin
      failures++; $display("FAIL zero_ack got=%0d/%h/%0d exp=1/aa/%0d", tx_cnt, tx_last, tx_cyc, c + 2);
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
  endtask

  task automatic test_len_error();
    int c;
    do_reset();
    send_word(32'h0000_0011, c);
    idle(6);
    checks++;
    if (tx_cnt !== 1 || tx_last !== 8'hEE) begin
      failures++; $display("FAIL err_ack got=%0d/%h exp=1/ee", tx_cnt, tx_last);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL err_flags got=done%b err%b exp=done0 err1", done, error);
    end
    send_word(32'h0000_0001, c);
    send_word(32'hDEAD_BEEF, c);
    idle(4);
    checks++;
    if (wr_cnt !== 0 || tx_cnt !== 1) begin
      failures++; $display("FAIL err_ignore got=wr%0d tx%0d exp=wr0 tx1", wr_cnt, tx_cnt);
    end
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL err_sticky got=done%b err%b exp=done0 err1", done, error);
    end
  endtask

  task automatic test_len_depth();
    int c;
    logic [31:0] exp_d;
    do_reset();
    send_word(32'h0000_0010, c);
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
      send_word(exp_d, c);
    end
    idle(6);
    checks++;
    if (wr_cnt !== 16) begin failures++; $display("FAIL depth_wr_cnt got=%0d exp=16", wr_cnt); end
    for (int i = 0; i < 16; i++) begin
      exp_d = 32'hA500_0000 + 32'(i) * 32'h0001_0203;
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_d) begin
        failures++; $display("FAIL depth_w%0d got=%h@%0d exp=%h@%0d", i, wr_data[i], wr_addr[i], exp_d, i);
      end
    end
    checks++;
    if (done !== 1'b1 || tx_last !== 8'hAA || tx_cnt !== 1) begin
      failures++; $display("FAIL depth_done got=%b/%h/%0d exp=1/aa/1", done, tx_last, tx_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int lc [3];
    logic [31:0] d [3];
    d[0] = 32'h0102_0304;
    d[1] = 32'hF0E0_D0C0;
    d[2] = 32'h7F80_01FE;
    do_reset();
    send_word(32'h0000_0003, c);
    for (int i = 0; i < 3; i++) begin
      send_word(d[i], c);
      lc[i] = c;
    end
    idle(6);
    checks++;
    if (wr_cnt !== 3) begin failures++; $display("FAIL b2b_wr_cnt got=%0d exp=3", wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== d[i] || wr_cyc[i] !== lc[i] + 1) begin
        failures++;
        $display("FAIL b2b_w%0d got=%h@%0d cyc%0d exp=%h@%0d cyc%0d",
                 i, wr_data[i], wr_addr[i], wr_cyc[i], d[i], i, lc[i] + 1);
      end
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
  endtask

  task automatic test_tx_busy();
    int c;
    int m;
    do_reset();
    tx_busy = 1'b1;
    send_word(32'h0000_0001, c);
    send_word(32'hCAFE_F00D, c);
    idle(50);
    checks++;
    if (tx_cnt !== 0 || done !== 1'b0) begin
      failures++; $display("FAIL busy_hold got=tx%0d done%b exp=tx0 done0", tx_cnt, done);
    end
    m = cyc;
    tx_busy = 1'b0;
    idle(6);
    checks++;
    if (tx_cnt !== 1 || tx_cyc !== m + 1 || tx_last !== 8'hAA) begin
      failures++; $display("FAIL busy_tx got=%0d@%0d/%h exp=1@%0d/aa", tx_cnt, tx_cyc, tx_last, m + 1);
    end
    checks++;
    if (done_cyc !== m + 2) begin failures++; $display("FAIL busy_done got=%0d exp=%0d", done_cyc, m + 2); end
    checks++;
    if (wr_cnt !== 1 || wr_data[0] !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL busy_wr got=%0d/%h exp=1/cafef00d", wr_cnt, wr_data[0]);
    end
  endtask

  task automatic test_reset_abort();
    int c;
    logic [31:0] img [3];
    img[0] = 32'h0000_0002;
    img[1] = 32'h1111_2222;
    img[2] = 32'h3333_4444;
    do_reset();
    send_word(img[0], c);
    send_byte(8'h11, c);
    send_byte(8'h11, c);
    rstn = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || imem_we !== 1'b0) begin
      failures++; $display("FAIL abort_clear got=done%b we%b exp=00", done, imem_we);
    end
    do_reset();
    send_word(32'h0000_0002, c);
    send_word(32'h5555_6666, c);
    send_word(32'h7777_8888, c);
    idle(6);
    checks++;
    if (wr_cnt !== 2) begin failures++; $display("FAIL abort_wr_cnt got=%0d exp=2", wr_cnt); end
    checks++;
    if (wr_addr[0] !== 4'd0 || wr_data[0] !== 32'h5555_6666 ||
        wr_addr[1] !== 4'd1 || wr_data[1] !== 32'h7777_8888) begin
      failures++;
      $display("FAIL abort_words got=%h@%0d %h@%0d exp=55556666@0 77778888@1",
               wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
    checks++;
    if (done !== 1'b1 || tx_cnt !== 1) begin
      failures++; $display("FAIL abort_done got=%b/%0d exp=1/1", done, tx_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    tx_cnt   = 0;
    tx_cyc   = -1;
    tx_last  = 8'h00;
    done_cyc = -1;
    rstn     = 1'b0;
    rx_ready = 1'b0;
    tx_busy  = 1'b0;
    rdata    = 8'h00;
    test_reset();
    test_two_words();
    test_len_zero();
    test_len_error();
    test_len_depth();
    test_back_to_back();
    test_tx_busy();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time loader between `uart_rx` and the instruction RAM of the multicycle core. After reset it takes a length-prefixed big-endian program image from the UART byte stream and writes it word by word into instruction memory from address 0. It then sends a one-byte acknowledgement through `uart_tx` and raises `done`, which releases the core from reset.

## Interface
- `ADDR_W`, 15, instruction-memory word-address width (memory is word-addressed; PC steps by 1).
- `DEPTH`, 2**ADDR_W, maximum accepted word count.
- `ACK_OK`, 8'hAA, byte sent on successful load.
- `ACK_ERR`, 8'hEE, byte sent when the length is rejected.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rdata`  in  8  received byte from `uart_rx`; valid in the cycle `rx_ready`=1.
- `rx_ready`  in  1  one-cycle strobe from `uart_rx`.
- `tx_busy`  in  1  `uart_tx` busy flag.
- `tx_data`  out  8  byte to transmit.
- `tx_start`  out  1  one-cycle transmit strobe.
- `imem_we`  out  1  instruction-RAM write enable, one-cycle pulse.
- `imem_addr`  out  ADDR_W  write address.
- `imem_wdata`  out  32  write data.
- `done`  out  1  load complete; drives core reset release.
- `error`  out  1  length rejected; sticky.

## Operation
- States: `S_LEN`, `S_DATA`, `S_ACK`, `S_DONE`, `S_ERR`, `S_ACKERR`. Reset state is `S_LEN`.
- Byte assembly:
  - 2-bit byte counter `bc` and 32-bit shift register `sh`.
  - On each accepted byte: `sh <= {sh[23:0], rdata}` and `bc <= bc+1` (wraps 3→0).
  - A word is complete when a byte is accepted with `bc==3`. The first byte received is the MSB.
- `S_LEN`:
  - The completed word is latched as `len` (32-bit unsigned).
  - If `len > DEPTH`, go to `S_ACKERR`.
  - If `len == 0`, go to `S_ACK`.
  - Otherwise go to `S_DATA` with word counter `wc <= 0`.
- `S_DATA`:
  - Each completed word writes `imem_wdata <= word` and `imem_addr <= wc[ADDR_W-1:0]`, and pulses `imem_we`. Then `wc <= wc+1`.
  - When the word written has `wc == len-1`, go to `S_ACK`.
  - `wc` is ADDR_W+1 bits wide so that `DEPTH` words never wrap.
- `S_ACK` / `S_ACKERR`:
  - Wait until `tx_busy==0`.
  - In that cycle: `tx_data <= ACK_OK` (or `ACK_ERR`), `tx_start <= 1` for one cycle.
  - Then go to `S_DONE` (or `S_ERR`).
- `S_DONE`: `done=1`. `S_ERR`: `error=1`, `done=0`. Both states are terminal until reset.
- `rx_ready` in `S_ACK`, `S_ACKERR`, `S_DONE` or `S_ERR` is ignored. Those bytes belong to the running program and go to the core's own `rdata_reg` path.
- Reset asserted mid-load aborts immediately:
  - All state clears and `done`/`imem_we` drop.
  - The partial image stays in RAM and is overwritten by the next load.

## Timing
- Reset values: `tx_data=0`, `tx_start=0`, `imem_we=0`, `imem_addr=0`, `imem_wdata=0`, `done=0`, `error=0`, `bc=0`, `sh=0`, `len=0`, `wc=0`.
- All outputs are registered. There are no combinational input-to-output paths.
- The 4th byte of a word is accepted in cycle T. `imem_we`, `imem_addr` and `imem_wdata` are valid in T+1 only.
- `rx_ready` may assert in consecutive cycles. Every strobe is accepted with no loss and no backpressure. A data strobe in cycle T+1 overlapping a write pulse is legal.
- Last word accepted in T: write in T+1, state is `S_ACK` in T+1. If `tx_busy` is low in T+1, `tx_start` is high in T+2 and `done` is high from T+3.
- `len==0` accepted in T: state is `S_ACK` in T+1. No `imem_we` pulse ever occurs.
- `tx_busy` held high: `tx_start` is withheld until the first cycle it is sampled low. The strobe then fires exactly once.

## Test plan
- Bytes `00 00 00 02, 12 34 56 78, 9A BC DE F0` → writes 0x12345678@0 and 0x9ABCDEF0@1 (one `imem_we` each); `tx_data`=0xAA with a single `tx_start`; `done`=1.
- Bytes `00 00 00 00` → no `imem_we`; ack 0xAA; `done`=1.
- With ADDR_W=4, bytes `00 00 00 11` (17 > 16) → ack 0xEE; `error`=1; `done`=0; further bytes produce no writes.
- 3-word image with `rx_ready` high on 12 consecutive cycles → 3 writes at addresses 0,1,2, each 1 cycle after its 4th byte; data is exact.
- `tx_busy` forced high for 50 cycles after the last word → `tx_start` stays 0 for those 50 cycles, then is high for exactly 1 cycle; `done` follows 1 cycle later.
- `rstn` pulsed low after 6 of 12 image bytes, then a full 2-word image is sent → the first partial word is discarded, the new words land at 0 and 1, and `done`=1.
